// File: rtl/hyster_pkg.sv
// Shared types for the hysteresis-thresholding stage: FSM encoding and
// default-width pixel/column types (a column is rows r-1, r, r+1 at index 0..2).
package hyster_pkg;
    localparam int PIX_W = 5;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [2:0]     column_t;
endpackage

// File: rtl/hyster_if.sv
// Stream bus for hyster_stream: column input handshake, runtime thresholds
// and the per-pixel output with its position flags.
interface hyster_if #(
    parameter int BIT_LENGTH = 5,
    parameter int COL_W      = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIT_LENGTH-1:0] pixel_in0;
    logic [BIT_LENGTH-1:0] pixel_in1;
    logic [BIT_LENGTH-1:0] pixel_in2;
    logic [BIT_LENGTH-1:0] weak_th;
    logic [BIT_LENGTH-1:0] strong_th;
    logic                  out_valid;
    logic                  pixel_out;
    logic [COL_W-1:0]      out_col;
    logic                  out_eol;
    logic                  frame_done;

    modport master (
        output in_valid, pixel_in0, pixel_in1, pixel_in2, weak_th, strong_th,
        input  in_ready, out_valid, pixel_out, out_col, out_eol, frame_done
    );

    modport slave (
        input  in_valid, pixel_in0, pixel_in1, pixel_in2, weak_th, strong_th,
        output in_ready, out_valid, pixel_out, out_col, out_eol, frame_done
    );
endinterface

// File: rtl/hyster_decide.sv
// Combinational edge decision on a 3x3 window. Define HYSTER_CONN4_EN to
// restrict the neighbour set to the 4-connected cells.
module hyster_decide
    import hyster_pkg::*;
#(
    parameter int BIT_LENGTH = PIX_W
) (
    input  logic [2:0][BIT_LENGTH-1:0] win_l,
    input  logic [2:0][BIT_LENGTH-1:0] win_c,
    input  logic [2:0][BIT_LENGTH-1:0] win_r,
    input  logic [BIT_LENGTH-1:0]      weak_th,
    input  logic [BIT_LENGTH-1:0]      strong_th,
    output logic                       is_edge
);
    logic strong_nb;

`ifdef HYSTER_CONN4_EN
    logic unused_corners;
    assign unused_corners = ^{win_l[0], win_l[2], win_r[0], win_r[2]};
    assign strong_nb = (win_l[1] >= strong_th) || (win_r[1] >= strong_th) ||
                       (win_c[0] >= strong_th) || (win_c[2] >= strong_th);
`else
    always_comb begin
        strong_nb = (win_c[0] >= strong_th) || (win_c[2] >= strong_th);
        for (int i = 0; i < 3; i++)
            strong_nb = strong_nb || (win_l[i] >= strong_th) || (win_r[i] >= strong_th);
    end
`endif

    // weak test first, so weak_th > strong_th suppresses everything below weak
    always_comb begin
        if (win_c[1] < weak_th)        is_edge = 1'b0;
        else if (win_c[1] >= strong_th) is_edge = 1'b1;
        else                            is_edge = strong_nb;
    end
endmodule

// File: rtl/hyster_stream.sv
// Hysteresis-thresholding stage: 3-column sliding window with zero padding at
// the row borders (end-of-row FLUSH cycle), row/frame tracking. Option: HYSTER_CONN4_EN.
module hyster_stream
    import hyster_pkg::*;
#(
    parameter int BIT_LENGTH = PIX_W,
    parameter int IMG_WIDTH  = 960,
    parameter int IMG_HEIGHT = 720,
    parameter int COL_W      = $clog2(IMG_WIDTH)
) (
    input logic     clk,
    input logic     reset,
    hyster_if.slave bus
);
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    typedef logic [2:0][BIT_LENGTH-1:0] wcol_t;

    state_t                state;
    wcol_t                 win_l, win_c, win_r, in_col;
    logic [BIT_LENGTH-1:0] weak_q, strong_q;
    logic [COL_W-1:0]      col_in, pend_col;
    logic [ROW_W-1:0]      row;
    logic                  rdy, pend, pend_eol, pend_fd, decision, accept;
    logic                  out_valid_q, pixel_out_q, out_eol_q, frame_done_q;
    logic [COL_W-1:0]      out_col_q;

    assign in_col = {bus.pixel_in2, bus.pixel_in1, bus.pixel_in0};
    assign accept = bus.in_valid && rdy;

    assign bus.in_ready   = rdy;
    assign bus.out_valid  = out_valid_q;
    assign bus.pixel_out  = pixel_out_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_eol    = out_eol_q;
    assign bus.frame_done = frame_done_q;

    hyster_decide #(.BIT_LENGTH(BIT_LENGTH)) u_decide (
        .win_l    (win_l),
        .win_c    (win_c),
        .win_r    (win_r),
        .weak_th  (weak_q),
        .strong_th(strong_q),
        .is_edge  (decision)
    );

    // pend marks a centre column formed on the previous edge; its pixel is
    // evaluated on the current (pre-edge) window and registered now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            win_l        <= '0;
            win_c        <= '0;
            win_r        <= '0;
            weak_q       <= '0;
            strong_q     <= '0;
            col_in       <= '0;
            pend_col     <= '0;
            row          <= '0;
            rdy          <= 1'b0;
            pend         <= 1'b0;
            pend_eol     <= 1'b0;
            pend_fd      <= 1'b0;
            out_valid_q  <= 1'b0;
            pixel_out_q  <= 1'b0;
            out_col_q    <= '0;
            out_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= pend;
            pixel_out_q  <= pend && decision;
            out_col_q    <= pend ? pend_col : '0;
            out_eol_q    <= pend && pend_eol;
            frame_done_q <= pend && pend_fd;
            pend         <= 1'b0;
            pend_eol     <= 1'b0;
            pend_fd      <= 1'b0;

            case (state)
                IDLE: begin
                    rdy <= 1'b1;
                    if (accept) begin
                        win_l    <= '0;
                        win_c    <= '0;
                        win_r    <= in_col;
                        weak_q   <= bus.weak_th;
                        strong_q <= bus.strong_th;
                        col_in   <= COL_W'(1);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        win_l    <= win_c;
                        win_c    <= win_r;
                        win_r    <= in_col;
                        pend     <= 1'b1;
                        pend_col <= col_in - COL_W'(1);
                        if (col_in == LAST_COL) begin
                            rdy   <= 1'b0;
                            state <= FLUSH;
                        end else begin
                            col_in <= col_in + COL_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    win_l    <= win_c;
                    win_c    <= win_r;
                    win_r    <= '0;
                    pend     <= 1'b1;
                    pend_col <= LAST_COL;
                    pend_eol <= 1'b1;
                    pend_fd  <= (row == LAST_ROW);
                    row      <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
                    col_in   <= '0;
                    rdy      <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/hyster_stream.md
Name: hyster_stream

Overview:
- Parametrised hysteresis-thresholding stage for the Canny edge pipeline.
- Consumes one 3-row pixel column per accepted transfer from the upstream line buffer, where rows r-1, r and r+1 arrive together.
- Emits one binary edge pixel per column for row r.
- Adds features the previous generation lacked:
  - runtime weak/strong thresholds;
  - an in_valid/in_ready handshake with stall support;
  - zero-padding at the left and right image borders via an end-of-row flush cycle;
  - row/frame tracking.

Parameters:
- BIT_LENGTH, 5, pixel magnitude width.
- IMG_WIDTH, 960, columns per row (must be 2 or more).
- IMG_HEIGHT, 720, rows per frame.
- COL_W, clog2(IMG_WIDTH), width of the column index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream column valid.
- in_ready  out  1  column accepted when in_valid && in_ready.
- pixel_in0  in  BIT_LENGTH  row r-1.
- pixel_in1  in  BIT_LENGTH  row r (centre row).
- pixel_in2  in  BIT_LENGTH  row r+1.
- weak_th  in  BIT_LENGTH  weak threshold.
- strong_th  in  BIT_LENGTH  strong threshold.
- out_valid  out  1  pixel_out valid; no backpressure.
- pixel_out  out  1  edge decision.
- out_col  out  COL_W  column index of pixel_out.
- out_eol  out  1  high with the last pixel of each row.
- frame_done  out  1  one-cycle pulse with the last pixel of the last row.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; window, counters and latched thresholds cleared.
  - out_valid, pixel_out, out_col, out_eol and frame_done are all 0.
  - in_ready=0 while reset is asserted.
  - Reset mid-row or mid-frame abandons all partial work; no output follows.
- Window: three column registers, L (left), C (centre) and R (right), each 3 x BIT_LENGTH.
  - On accept: L<=C, C<=R, R<=input.
- State IDLE (in_ready=1), waiting for column 0 of a row:
  - On accept: R<=input, C<=0, L<=0.
  - weak_th and strong_th are latched for the whole row.
  - col_in<=1; go to RUN.
- State RUN (in_ready=1):
  - On accept of column k, the window shifts and a compute is scheduled for centre column k-1.
  - If k==IMG_WIDTH-1, go to FLUSH.
  - in_valid=0 stalls: window held, no output.
- State FLUSH (in_ready=0, exactly one cycle):
  - Window shifts with a zero column (R<=0); compute scheduled for column IMG_WIDTH-1.
  - Row counter increments, wrapping at IMG_HEIGHT; go to IDLE.
- Output timing:
  - The pixel for a centre column is registered on the edge after that centre is formed, evaluated on the pre-edge window.
  - Latency: column c+1 accepted at edge E gives pixel c valid after edge E+1.
  - out_valid is high for one cycle per pixel; out_col increments 0..IMG_WIDTH-1.
  - out_eol=1 for col IMG_WIDTH-1.
  - frame_done=1 with that same pixel when row==IMG_HEIGHT-1.
- Decision, using the centre C[1] and neighbour set N (default: all 8 non-centre cells), priority order:
  1. C[1] < weak → 0.
  2. C[1] >= strong → 1.
  3. Otherwise → 1 if max(N) >= strong, else 0.
- All comparisons are unsigned at BIT_LENGTH.
- weak_th > strong_th is legal and resolved by the priority order above.
- A new row's column 0 may be accepted in the cycle immediately after FLUSH. Throughput is IMG_WIDTH+1 cycles per row at full in_valid.

Optional Feature:
- Macro: HYSTER_CONN4_EN.
- Defined: N = {L[1], R[1], C[0], C[2]} (4-connectivity).
- Undefined: N = all 8 neighbours.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package hyster_pkg holds:
  - state encoding IDLE/RUN/FLUSH;
  - pixel_t (BIT_LENGTH);
  - column typedef (3 x pixel_t).
- One natural sub-module: hyster_decide. Purely combinational; takes the window and the thresholds and returns the edge bit, with the HYSTER_CONN4_EN selection inside.
- The top level holds the FSM, counters, window and output registers.

Test Plan:
All scenarios use BIT_LENGTH=5, IMG_WIDTH=4, IMG_HEIGHT=2, weak=4, strong=10.
1. All-zero frame, continuous in_valid → 8 pixels, all 0; out_col 0,1,2,3,0,1,2,3; out_eol on cols 3; frame_done once; in_ready low exactly one cycle per row.
2. Centre row 12,5,5,3, others 0 → pixels 1,1,0,0. Col1 is weak with strong left neighbour; col2's neighbours are 5/3; col3 is below weak.
3. Weak centre 6 at col 0, strong 15 only at row r-1 col 3 → col 0 output 0, showing no wrap-around across the row border.
4. Diagonal strong: rows r-1 col0 = 15, centre col1 = 6 → default build 1; HYSTER_CONN4_EN build 0.
5. Stall: drop in_valid for 3 cycles after column 1 → no out_valid during the stall; outputs resume with unchanged values and order.
6. Assert reset for 1 cycle after column 2 of row 0 → all outputs 0 immediately; next column is treated as row 0, col 0; no frame_done from the aborted frame.
